// File: rtl/arb_pkg.sv
// Shared types for the weighted round-robin arbiter: FSM states and arbitration modes.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set over req, searching upward from ptr and
// wrapping from N-1 back to 0. ptr = 0 gives plain lowest-index priority.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin / fixed-priority arbiter with registered one-hot grants.
// An owner keeps the grant for up to its burst weight in cycles (weight 0 acts
// as 1), loses it as soon as it drops its request, and is replaced on the same
// edge by the next winner so handovers never leave an idle bubble.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  mode,
  output logic [N-1:0]          gnt,
  output logic [IDX_W-1:0]      gnt_id,
  output logic                  gnt_valid
);

  arb_state_e          state, state_nxt;
  arb_mode_e           mode_e;
  logic [N-1:0]        gnt_nxt;
  logic [IDX_W-1:0]    gnt_id_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [WEIGHT_W-1:0] credit, credit_nxt;
  logic [WEIGHT_W-1:0] effw, effw_nxt;

  logic [IDX_W-1:0]    pick_ptr;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [WEIGHT_W-1:0] win_w;
  logic [WEIGHT_W-1:0] win_effw;
  logic                owner_req;
  logic                release_own;
  logic                arb;

  assign mode_e   = arb_mode_e'(mode);
  // Fixed priority is round-robin search anchored at index 0.
  assign pick_ptr = (mode_e == ARB_RR) ? ptr : '0;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Burst length is latched from the winner's weight at issue time.
  assign win_w    = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
  assign win_effw = (win_w == '0) ? WEIGHT_W'(1) : win_w;

  assign owner_req   = req[gnt_id];
  assign release_own = !owner_req || (credit == effw - 1'b1);
  assign gnt_valid   = |gnt;

  // Next-state: hold, extend the burst, hand over, or fall back to IDLE.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    effw_nxt   = effw;
    arb        = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) arb = 1'b1;
      end
      GRANT: begin
        if (!release_own) begin
          credit_nxt = credit + 1'b1;
        end else if (pick_found) begin
          arb = 1'b1;
        end else begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
          credit_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (arb) begin
      state_nxt         = GRANT;
      gnt_nxt           = '0;
      gnt_nxt[pick_idx] = 1'b1;
      gnt_id_nxt        = pick_idx;
      credit_nxt        = '0;
      effw_nxt          = win_effw;
      if (mode_e == ARB_RR) begin
        if (int'(pick_idx) == N - 1) ptr_nxt = '0;
        else                         ptr_nxt = pick_idx + 1'b1;
      end
    end
  end

  // State register; reset drops any grant immediately, even mid-burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
      credit <= '0;
      effw   <= WEIGHT_W'(1);
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= gnt_id_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      effw   <= effw_nxt;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter: a cycle-level reference model checked every
// cycle, plus literal grant sequences for the key scenarios.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic            mode;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            gnt_valid;

  int n_checks = 0;
  int n_pass   = 0;

  wrr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .weight    (weight),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
  endtask

  // Reference model: who owns the resource, how many cycles they have held it,
  // their burst limit, and where the round-robin search starts next.
  int m_owner = -1;
  int m_used  = 0;
  int m_lim   = 1;
  int m_ptr   = 0;
  int m_start, m_cand;
  bit m_pick;
  logic [N-1:0] exp_gnt;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_used = 0; m_lim = 1; m_ptr = 0;
    end else begin
      m_pick = (m_owner < 0);
      if (!m_pick) begin
        if (!req[m_owner] || m_used == m_lim) m_pick = 1;
        else m_used++;
      end
      if (m_pick) begin
        m_start = mode ? m_ptr : 0;
        m_owner = -1;
        for (int k = 0; k < N; k++) begin
          m_cand = (m_start + k) % N;
          if (m_owner < 0 && req[m_cand]) m_owner = m_cand;
        end
        if (m_owner >= 0) begin
          m_lim  = int'(weight[m_owner*WW +: WW]);
          if (m_lim == 0) m_lim = 1;
          m_used = 1;
          if (mode) m_ptr = (m_owner + 1) % N;
        end
      end
    end
    #1;
    exp_gnt = '0;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    chk("model_gnt", 32'(gnt), 32'(exp_gnt));
    chk("model_gnt_valid", 32'(gnt_valid), 32'(exp_gnt != '0));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (m_owner >= 0) chk("model_gnt_id", 32'(gnt_id), 32'(m_owner));
  end

  // Advance one clock; literal checks happen after the model compare.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_gnt(input string name, input logic [N-1:0] e);
    cyc();
    chk(name, 32'(gnt), 32'(e));
  endtask

  logic [N-1:0] wseq [8];

  initial begin
    rst    = 1'b1;
    req    = 4'b1111;
    mode   = 1'b1;
    weight = {4'd1, 4'd1, 4'd1, 4'd1};

    // Reset held with all requests pending
    expect_gnt("reset_c0", 4'b0000);
    expect_gnt("reset_c1", 4'b0000);
    chk("reset_valid", 32'(gnt_valid), 32'd0);
    rst = 1'b0;
    expect_gnt("post_reset", 4'b0001);
    req = 4'b0000;
    expect_gnt("drain", 4'b0000);

    // Walk single requesters
    req = 4'b0001; expect_gnt("walk0", 4'b0001);
    req = 4'b0010; expect_gnt("walk1", 4'b0010);
    req = 4'b0100; expect_gnt("walk2", 4'b0100);
    req = 4'b1000; expect_gnt("walk3", 4'b1000);
    req = 4'b0000; expect_gnt("walk_idle", 4'b0000);

    // Round-robin fairness with everyone requesting
    req = 4'b1111;
    expect_gnt("rr0", 4'b0001);
    expect_gnt("rr1", 4'b0010);
    expect_gnt("rr2", 4'b0100);
    expect_gnt("rr3", 4'b1000);
    expect_gnt("rr4", 4'b0001);

    // Weighted burst: requester 3 gets three cycles per turn
    rst = 1'b1; req = 4'b0000;
    expect_gnt("wb_reset", 4'b0000);
    rst = 1'b0; req = 4'b1001;
    weight = {4'd3, 4'd1, 4'd1, 4'd1};
    wseq = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b1000};
    for (int i = 0; i < 8; i++) expect_gnt($sformatf("wburst%0d", i), wseq[i]);

    // Weight 0 behaves as 1: requester 3 alternates every cycle
    weight = {4'd0, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) cyc();

    // Fixed priority: lowest index re-wins after each burst
    rst = 1'b1; req = 4'b0000;
    expect_gnt("fp_reset", 4'b0000);
    rst = 1'b0; mode = 1'b0; req = 4'b0110;
    weight = {4'd2, 4'd2, 4'd2, 4'd2};
    for (int i = 0; i < 5; i++) expect_gnt($sformatf("fixed%0d", i), 4'b0010);
    req = 4'b0100;
    expect_gnt("fixed_drop", 4'b0100);

    // Early release hands over without a gap; reset mid-burst clears pointer
    rst = 1'b1; req = 4'b0000;
    expect_gnt("er_reset", 4'b0000);
    rst = 1'b0; mode = 1'b1;
    weight = {4'd4, 4'd4, 4'd4, 4'd4};
    req = 4'b0100; expect_gnt("er_own2", 4'b0100);
    req = 4'b0101; expect_gnt("er_hold2", 4'b0100);
    req = 4'b0001; expect_gnt("er_handover", 4'b0001);
    req = 4'b0011; expect_gnt("er_burst0", 4'b0001);
    rst = 1'b1;    expect_gnt("er_midreset", 4'b0000);
    rst = 1'b0;    expect_gnt("er_ptr_zero", 4'b0001);

    // Mode change mid-burst does not cut the burst short
    mode = 1'b0;
    expect_gnt("mode_hold", 4'b0001);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
Parametrised weighted round-robin arbiter; next generation of the team's 4-requester grant arbiter. Arbitrates N requesters onto one shared resource with registered one-hot grants. Supports per-requester burst weights and a runtime select between round-robin and fixed-priority modes. Sits in front of shared buses/memories; the grant bus stays one-hot-or-zero on every cycle.

Parameters:
N, 4, number of requesters (2..32)
WEIGHT_W, 4, width of each per-requester burst weight field
IDX_W, $clog2(N), width of grant index (derived, not overridable)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request vector, bit i = requester i
weight  input  N*WEIGHT_W  burst weight per requester, field i = bits [i*WEIGHT_W +: WEIGHT_W]
mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
gnt  output  N  registered grant, one-hot or zero
gnt_id  output  IDX_W  index of current owner, valid when gnt_valid=1
gnt_valid  output  1  high when any grant is asserted

Behaviour:
- Reset (rst=1 at posedge): gnt=0, gnt_id=0, gnt_valid=0, rr pointer=0, credit=0, state=IDLE. Applies mid-burst; grant drops at that edge, no completion.
- State machine:
  - IDLE: gnt=0. If |req, pick winner w; next edge gnt=onehot(w), credit=0, state=GRANT. Otherwise stay.
  - GRANT: owner o. Release condition = !req[o] OR credit == eff_weight-1.
    - No release: gnt holds, credit++.
    - Release, other bits of req nonzero (or req[o] still high): pick new winner same cycle, load next edge, credit=0, stay GRANT. No idle bubble.
    - Release, req==0 (after excluding a dropped owner): next edge gnt=0, state=IDLE.
- Latency: req to gnt = 1 cycle from IDLE; back-to-back handover = 0 bubble cycles.
- eff_weight = weight[o] sampled on the cycle the grant is issued; weight 0 treated as 1. Weight changes during a burst do not affect it.
- Winner selection:
  - mode=1: first set bit of req searching upward from pointer, wrapping N-1 -> 0. When a grant to w is issued, pointer <= (w+1) mod N. Exhausted owner still requesting, with no other request, wins again with a fresh burst.
  - mode=0: lowest set index; pointer unchanged. The burst limit still applies; the same lowest index may immediately re-win.
- mode change takes effect at the next arbitration point only; it never truncates a burst.
- Invariants: $onehot0(gnt) every cycle; gnt_valid == |gnt; gnt_id == index of set gnt bit; gnt[i] never asserted unless req[i] was high in the preceding cycle.
- Owner dropping req: grant is removed at the next edge (at most 1 cycle of grant after the drop).

Decomposition:
- Package arb_pkg: state enum {IDLE, GRANT}, mode enum {ARB_FIXED=0, ARB_RR=1}.
- Sub-module rr_pick: combinational find-first-set with rotating start pointer, parameter N. Inputs req and ptr; outputs found, idx. Instantiated once; fixed mode drives ptr=0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0 throughout; after rst=0, gnt=4'b0001 next cycle.
- Walk (mode=1, all weights=1): req=0001, 0010, 0100, 1000 one cycle each -> gnt follows one cycle later, each one-hot; req=0 -> gnt=0 next cycle.
- RR fairness (mode=1, weights=1): req held at 4'b1111 -> gnt sequence 0001, 0010, 0100, 1000, 0001 with no gaps.
- Weighted burst (mode=1): weights {1,1,1,3} (req3 weight=3), req=4'b1001 held -> gnt 0001 x1, 1000 x3, 0001 x1, repeat.
- Fixed priority (mode=0, weights=2): req=4'b0110 held -> gnt 0010 every cycle (re-wins after each burst); drop req[1] -> gnt=0100 next cycle.
- Early release and mid-burst reset: weight=4, owner 2 drops req after 1 cycle with req[0] high -> gnt=0001 next cycle with no gap; assert rst mid-burst -> gnt=0 at that edge and pointer=0.
